// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the load/store data memory.
// size_e mirrors the RISC-V load/store funct3 encoding. The helpers work on a
// 64-bit word and 3-bit lane offset. Narrower instances zero-extend into them
// and truncate the results.
package dmem_lsu_pkg;

  typedef enum logic [2:0] {
    SZ_B   = 3'b000,
    SZ_H   = 3'b001,
    SZ_W   = 3'b010,
    SZ_D   = 3'b011,
    SZ_BU  = 3'b100,
    SZ_HU  = 3'b101,
    SZ_WU  = 3'b110,
    SZ_RSV = 3'b111
  } size_e;

  // Byte enables covering the access, positioned at the lane offset.
  function automatic logic [7:0] lane_mask(size_e size, logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B, SZ_BU: base = 8'h01;
      SZ_H, SZ_HU: base = 8'h03;
      SZ_W, SZ_WU: base = 8'h0F;
      SZ_D:        base = 8'hFF;
      default:     base = 8'h00;
    endcase
    return base << offset;
  endfunction

  function automatic logic align_ok(size_e size, logic [2:0] addr_low);
    logic ok;
    case (size)
      SZ_H, SZ_HU: ok = (addr_low[0] == 1'b0);
      SZ_W, SZ_WU: ok = (addr_low[1:0] == 2'b00);
      SZ_D:        ok = (addr_low == 3'b000);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic size_legal(size_e size, int unsigned data_w);
    return (size != SZ_RSV) && !(data_w == 32 && (size == SZ_D || size == SZ_WU));
  endfunction

  // Right-justify the addressed bytes and extend to the full word.
  function automatic logic [63:0] load_extend(logic [63:0] word, size_e size,
                                              logic [2:0] offset);
    logic [63:0] sh;
    logic [63:0] res;
    sh = word >> {offset, 3'b000};
    case (size)
      SZ_B:    res = {{56{sh[7]}}, sh[7:0]};
      SZ_H:    res = {{48{sh[15]}}, sh[15:0]};
      SZ_W:    res = {{32{sh[31]}}, sh[31:0]};
      SZ_D:    res = sh;
      SZ_BU:   res = {56'h0, sh[7:0]};
      SZ_HU:   res = {48'h0, sh[15:0]};
      SZ_WU:   res = {32'h0, sh[31:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enabled word array for dmem_lsu.
// Ports: clk_i/rst_i (async active-high, loads RESET_VAL into every word),
//        idx_i word index shared by read and write, wr_be_i byte-lane write
//        enables, wr_data_i write data, rd_data_o combinational read of idx_i.
module dmem_bank #(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         IDX_W     = 8,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_W/8-1:0]   wr_be_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < DEPTH; w++) mem[w] <= RESET_VAL;
    end else begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_be_i[b]) mem[idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  assign rd_data_o = mem[idx_i];

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with load/store front end.
// Ports: clk_i/rst_i (async active-high); request channel req_valid_i/
//        req_ready_o with req_we_i, req_addr_i (byte address), req_size_i
//        (funct3), req_wdata_i (right-aligned); response channel rsp_valid_o/
//        rsp_ready_i with rsp_rdata_o (extended load data, 0 for stores and
//        errors) and rsp_err_o (misaligned or illegal size).
// One-entry response register gives 1-cycle latency; a new request can be
// accepted on the same edge the current response is consumed.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_size_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;

  size_e             req_sz;
  logic [2:0]        off3;
  logic              accept;
  logic              req_err;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] load_data;

  assign req_sz = size_e'(req_size_i);
  // Lane offset widened to the 3 bits the helpers expect.
  assign off3   = (DATA_W == 64) ? req_addr_i[2:0] : {1'b0, req_addr_i[1:0]};

  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign req_err     = !(size_legal(req_sz, DATA_W) && align_ok(req_sz, req_addr_i[2:0]));

  assign wr_be = (accept && req_we_i && !req_err) ? NB'(lane_mask(req_sz, off3)) : '0;

  dmem_bank #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .RESET_VAL(RESET_VAL)
  ) u_bank (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .idx_i    (req_addr_i[ADDR_W-1:OFF_W]),
    .wr_be_i  (wr_be),
    .wr_data_i(req_wdata_i << (8 * off3)),
    .rd_data_o(rd_word)
  );

  assign load_data = DATA_W'(load_extend(64'(rd_word), req_sz, off3));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_err_o   <= req_err;
      rsp_rdata_o <= (req_we_i || req_err) ? '0 : load_data;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a 32-bit and a 64-bit instance, both checked against a
// byte-array reference model with a queue of outstanding responses.
module tb_dmem_lsu;

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [9:0]  req_addr  [2];
  logic [2:0]  req_size  [2];
  logic [63:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_err   [2];
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  dmem_lsu #(.DATA_W(32), .ADDR_W(10), .RESET_VAL(32'h0)) u_dut32 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_size_i(req_size[0]), .req_wdata_i(req_wdata[0][31:0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rdata32), .rsp_err_o(rsp_err[0])
  );

  dmem_lsu #(.DATA_W(64), .ADDR_W(10), .RESET_VAL(64'h0)) u_dut64 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_size_i(req_size[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rdata64), .rsp_err_o(rsp_err[1])
  );

  logic [7:0] mem_m [2][1024];
  rsp_t       exp_q [2][$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_pop [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rdata_of(input int d);
    return (d != 0) ? rdata64 : {32'h0, rdata32};
  endfunction

  // Reference: byte-addressed memory, size = 1 << (funct3 % 4) bytes.
  function automatic rsp_t model_xact(input int d, input bit we, input int addr,
                                      input int size, input logic [63:0] wd);
    int          w;
    int          nb;
    bit          legal;
    logic [63:0] v;
    rsp_t        r;
    w     = (d != 0) ? 64 : 32;
    nb    = 1 << (size % 4);
    legal = (size != 7) && !(w == 32 && (size == 3 || size == 6));
    r     = '0;
    if (!legal || (addr % nb) != 0) begin
      r.err = 1'b1;
      return r;
    end
    if (we) begin
      for (int i = 0; i < nb; i++) mem_m[d][addr+i] = wd[8*i +: 8];
      return r;
    end
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[d][addr+i];
    if (size < 4 && nb < 8 && v[8*nb-1]) begin
      for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
    end
    if (w == 32) v[63:32] = '0;
    r.data = v;
    return r;
  endfunction

  // One clock: drive instance d (the other idles with rsp_ready=1), check
  // ready before the edge, update the model at the edge, check outputs after.
  task automatic tick(input int d, input bit v, input bit we, input int addr, input int size,
                      input logic [63:0] wd, input bit rr, output bit acc);
    bit hs;
    bit acc_k;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = (k == d) ? v : 1'b0;
      rsp_ready[k] = (k == d) ? rr : 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr[9:0];
      req_size[k]  = size[2:0];
      req_wdata[k] = wd;
    end
    #1;
    check_eq($sformatf("ready%0d", d), {63'h0, req_ready[d]}, {63'h0, (exp_q[d].size() == 0 || rr)});
    @(posedge clk);
    #1;
    acc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hs    = (exp_q[k].size() > 0) && rsp_ready[k];
      acc_k = req_valid[k] && (exp_q[k].size() == 0 || rsp_ready[k]);
      if (hs) begin
        void'(exp_q[k].pop_front());
        n_pop[k]++;
      end
      if (acc_k) exp_q[k].push_back(model_xact(k, req_we[k], int'(req_addr[k]),
                                               int'(req_size[k]), req_wdata[k]));
      if (k == d) acc = acc_k;
    end
    check_eq($sformatf("valid%0d", d), {63'h0, rsp_valid[d]}, {63'h0, exp_q[d].size() > 0});
    if (exp_q[d].size() > 0) begin
      check_eq($sformatf("rdata%0d", d), rdata_of(d), exp_q[d][0].data);
      check_eq($sformatf("err%0d", d), {63'h0, rsp_err[d]}, {63'h0, exp_q[d][0].err});
    end
  endtask

  task automatic idle(input int d);
    bit acc;
    tick(d, 1'b0, 1'b0, 0, 0, 64'h0, 1'b1, acc);
  endtask

  task automatic xact(input int d, input bit we, input int addr, input int size,
                      input logic [63:0] wd);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 16 && !acc; t++) tick(d, 1'b1, we, addr, size, wd, 1'b1, acc);
    if (!acc) check_eq("accept_timeout", 64'h0, 64'h1);
  endtask

  task automatic load_expect(input string tag, input int d, input int addr, input int size,
                             input logic [63:0] expv, input bit experr);
    xact(d, 1'b0, addr, size, 64'h0);
    check_eq(tag, rdata_of(d), expv);
    check_eq({tag, "_err"}, {63'h0, rsp_err[d]}, {63'h0, experr});
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) req_valid[k] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_valid%0d", k), {63'h0, rsp_valid[k]}, 64'h0);
      check_eq($sformatf("rst_err%0d", k), {63'h0, rsp_err[k]}, 64'h0);
      check_eq($sformatf("rst_rdata%0d", k), rdata_of(k), 64'h0);
      exp_q[k].delete();
      for (int a = 0; a < 1024; a++) mem_m[k][a] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          bp_addr [3];
    int          i;
    int          cyc;
    int          pops0;
    logic [63:0] first;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; rsp_ready[k] = 1'b1; req_we[k] = 1'b0;
      req_addr[k] = '0; req_size[k] = '0; req_wdata[k] = '0; n_pop[k] = 0;
      for (int a = 0; a < 1024; a++) mem_m[k][a] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Response pending and held, then reset drops it.
    tick(0, 1'b1, 1'b0, 'h20, 2, 64'h0, 1'b0, acc);
    tick(0, 1'b0, 1'b0, 0, 0, 64'h0, 1'b0, acc);
    check_eq("held_valid", {63'h0, rsp_valid[0]}, 64'h1);
    do_reset();
    load_expect("lw000", 0, 'h000, 2, 64'h0, 1'b0);

    xact(0, 1'b1, 'h010, 2, 64'hDEADBEEF);
    load_expect("lb013",  0, 'h013, 0, 64'hFFFFFFDE, 1'b0);
    load_expect("lbu013", 0, 'h013, 4, 64'h000000DE, 1'b0);
    load_expect("lh012",  0, 'h012, 1, 64'hFFFFDEAD, 1'b0);
    load_expect("lhu010", 0, 'h010, 5, 64'h0000BEEF, 1'b0);
    xact(0, 1'b1, 'h011, 0, 64'h55);
    load_expect("lw010_sb", 0, 'h010, 2, 64'hDEAD55EF, 1'b0);
    xact(0, 1'b1, 'h011, 1, 64'hFFFF);
    check_eq("sh011_err", {63'h0, rsp_err[0]}, 64'h1);
    check_eq("sh011_rdata", rdata_of(0), 64'h0);
    load_expect("lw012_mis", 0, 'h012, 2, 64'h0, 1'b1);
    load_expect("ld_on32",   0, 'h010, 3, 64'h0, 1'b1);
    load_expect("lw010_keep", 0, 'h010, 2, 64'hDEAD55EF, 1'b0);

    // Backpressure: three loads, consumer stalls for the first two cycles.
    xact(0, 1'b1, 'h014, 2, 64'h13572468);
    idle(0);
    bp_addr[0] = 'h010; bp_addr[1] = 'h014; bp_addr[2] = 'h012;
    pops0 = n_pop[0];
    i = 0;
    cyc = 0;
    first = '0;
    while (i < 3 && cyc < 20) begin
      tick(0, 1'b1, 1'b0, bp_addr[i], (i == 2) ? 1 : 2, 64'h0, (cyc >= 2), acc);
      if (cyc == 0) first = rdata_of(0);
      if (cyc == 1) check_eq("bp_stable", rdata_of(0), first);
      if (acc) i++;
      cyc++;
    end
    idle(0);
    check_eq("bp_issued", 64'(i), 64'd3);
    check_eq("bp_pops", 64'(n_pop[0] - pops0), 64'd3);

    // 64-bit instance.
    xact(1, 1'b1, 'h008, 3, 64'h0123456789ABCDEF);
    load_expect("d_lw00c",  1, 'h00C, 2, 64'h0000000001234567, 1'b0);
    load_expect("d_lwu008", 1, 'h008, 6, 64'h0000000089ABCDEF, 1'b0);
    load_expect("d_lw008",  1, 'h008, 2, 64'hFFFFFFFF89ABCDEF, 1'b0);
    load_expect("d_ld008",  1, 'h008, 3, 64'h0123456789ABCDEF, 1'b0);

    // Random traffic on both instances.
    for (int n = 0; n < 800; n++) begin
      int d;
      int addr;
      d    = int'($urandom_range(0, 1));
      addr = int'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) addr = addr & ~7;
      tick(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, addr,
           int'($urandom_range(0, 7)), {$urandom, $urandom}, $urandom_range(0, 3) != 0, acc);
    end
    idle(0);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
